// File: rtl/led_status_driver.sv
// led_status_driver: four-channel LED status driver.
// Each channel is off, on, blinking (shared phase) or event-flash (pulse
// stretched over a number of prescaler ticks). All channels share one
// prescaler tick and one blink phase.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   mode_in  2 bits per channel: 00 off, 01 on, 10 blink, 11 event-flash
//   event_in one-clk event pulses, one bit per channel
//   led_out  registered LED drive, inverted at the pin when ACTIVE_LOW=1
module led_status_driver #(
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned STRETCH_TICKS = 8,
    parameter int unsigned BLINK_TICKS   = 16,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mode_in,
    input  logic [3:0] event_in,
    output logic [3:0] led_out
);

    localparam int unsigned NUM_CH       = 4;
    localparam logic [3:0]  STRETCH_LOAD = 4'(STRETCH_TICKS);
    localparam logic [7:0]  BLINK_LAST   = 8'(BLINK_TICKS - 1);
    localparam logic [3:0]  LED_INACTIVE = {4{ACTIVE_LOW}};

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_EVENT = 2'b11;

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick_c;
    logic [7:0]           blink_cnt;
    logic                 blink_phase;
    logic [3:0]           stretch_cnt [NUM_CH];
    logic [3:0]           level_c;

    // Tick is the single cycle in which the prescaler is all ones.
    assign tick_c = &div_cnt;

    // Free-running prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // Blink half-period counter and shared phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (tick_c) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= 8'd0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    // Per-channel stretch counters; an event reloads and beats a same-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stretch_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (event_in[i]) begin
                    stretch_cnt[i] <= STRETCH_LOAD;
                end else if (tick_c && (stretch_cnt[i] != 4'd0)) begin
                    stretch_cnt[i] <= stretch_cnt[i] - 4'd1;
                end
            end
        end
    end

    // Logical level per channel; the live event bit gives one-clk latency in flash mode.
    always_comb begin
        level_c = 4'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            unique case (mode_in[2*i +: 2])
                MODE_OFF:   level_c[i] = 1'b0;
                MODE_ON:    level_c[i] = 1'b1;
                MODE_BLINK: level_c[i] = blink_phase;
                MODE_EVENT: level_c[i] = (stretch_cnt[i] != 4'd0) | event_in[i];
                default:    level_c[i] = 1'b0;
            endcase
        end
    end

    // Registered pin drive with optional polarity inversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= LED_INACTIVE;
        end else begin
            led_out <= level_c ^ LED_INACTIVE;
        end
    end

endmodule

// File: tb/tb_led_status_driver.sv
// Bench for led_status_driver: directed vector table, blink and async-reset
// sequences, and random traffic checked against a closed-form model.
module tb_led_status_driver;

    localparam int TICK = 4;  // 2^DIV_WIDTH with DIV_WIDTH=2
    localparam int ST   = 3;
    localparam int BT   = 2;

    logic       clk;
    logic       rst;
    logic [7:0] mode;
    logic [3:0] ev;
    logic [3:0] led;
    logic [7:0] mode2;
    logic [3:0] ev2;
    logic [3:0] led2;

    led_status_driver #(
        .DIV_WIDTH(2), .STRETCH_TICKS(ST), .BLINK_TICKS(BT), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .mode_in(mode), .event_in(ev), .led_out(led)
    );

    led_status_driver #(
        .DIV_WIDTH(2), .STRETCH_TICKS(ST), .BLINK_TICKS(BT), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .mode_in(mode2), .event_in(ev2), .led_out(led2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [7:0] md;
        logic [3:0] e;
        logic [3:0] exp;
        int         n;
    } vec_t;

    vec_t       tbl [12];
    int         edge_n;
    int         last_ev [4];
    logic [7:0] sbq [$];
    int         chk_cnt;
    int         pass_cnt;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected led after edge m: phase and stretch derived from edge counts.
    function automatic logic [3:0] model_led(input logic [7:0] md, input logic [3:0] e, input int m);
        logic [3:0] r;
        logic       ph;
        int         s;
        r  = 4'h0;
        ph = (((m - 1) / (TICK * BT)) % 2) != 0;
        for (int i = 0; i < 4; i++) begin
            if (last_ev[i] < 0) s = 0;
            else s = ST - ((m - 1) / TICK - last_ev[i] / TICK);
            if (s < 0) s = 0;
            case (md[2*i +: 2])
                2'b00:   r[i] = 1'b0;
                2'b01:   r[i] = 1'b1;
                2'b10:   r[i] = ph;
                default: r[i] = (s != 0) || e[i];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < 4; i++) last_ev[i] = -1;
    endtask

    // One clock: drive, push expectation, sample after the edge, compare.
    task automatic step(input logic r, input logic [7:0] md, input logic [3:0] e,
                        input logic use_tbl, input logic [3:0] tbl_exp, input string name);
        logic [3:0] m_exp;
        logic [3:0] exp2;
        int         m;
        @(negedge clk);
        rst  = r;
        mode = md;
        ev   = e;
        if (r) begin
            model_reset();
            m_exp = 4'h0;
            exp2  = 4'hF;
        end else begin
            m     = edge_n + 1;
            m_exp = model_led(md, e, m);
            for (int i = 0; i < 4; i++) if (e[i]) last_ev[i] = m;
            edge_n = m;
            exp2   = 4'hE;
        end
        sbq.push_back({exp2, use_tbl ? tbl_exp : m_exp});
        @(posedge clk);
        #1;
        check(name, {led2, led}, sbq.pop_front());
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst      = 1'b1;
        mode     = 8'h55;
        ev       = 4'h0;
        mode2    = 8'h01;
        ev2      = 4'h0;
        model_reset();

        // Static modes, stretch, retrigger, same-cycle event/tick, hidden stretch.
        tbl[0]  = '{1'b1, 8'h55, 4'h0, 4'h0, 2};
        tbl[1]  = '{1'b0, 8'h55, 4'h0, 4'hF, 1};   // edge 1
        tbl[2]  = '{1'b0, 8'h00, 4'h0, 4'h0, 1};   // edge 2
        tbl[3]  = '{1'b0, 8'h0C, 4'h0, 4'h0, 1};   // edge 3
        tbl[4]  = '{1'b0, 8'h0C, 4'h2, 4'h2, 1};   // edge 4: event with tick
        tbl[5]  = '{1'b0, 8'h0C, 4'h0, 4'h2, 9};   // edges 5..13
        tbl[6]  = '{1'b0, 8'h0C, 4'h2, 4'h2, 1};   // edge 14: retrigger at count 1
        tbl[7]  = '{1'b0, 8'h0C, 4'h0, 4'h2, 10};  // edges 15..24
        tbl[8]  = '{1'b0, 8'h0C, 4'h0, 4'h0, 3};   // edges 25..27
        tbl[9]  = '{1'b0, 8'h00, 4'h2, 4'h0, 1};   // edge 28: event while off
        tbl[10] = '{1'b0, 8'h0C, 4'h0, 4'h2, 12};  // edges 29..40
        tbl[11] = '{1'b0, 8'h0C, 4'h0, 4'h0, 1};   // edge 41

        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                step(tbl[k].r, tbl[k].md, tbl[k].e, 1'b1, tbl[k].exp, $sformatf("tbl%0d", k));
            end
        end

        // Blink from reset release: 0 for 8 edges, then F/0 every 8.
        step(1'b1, 8'hAA, 4'h0, 1'b0, 4'h0, "blink_rst");
        for (int j = 0; j < 34; j++) begin
            step(1'b0, 8'hAA, 4'h0, 1'b1,
                 ((j / 8) % 2 == 1) ? 4'hF : 4'h0, "blink");
        end

        // Blink plus stretch, then async reset between edges.
        for (int j = 0; j < 21; j++) begin
            step(1'b0, 8'hAE, (j % 5 == 0) ? 4'h2 : 4'h0, 1'b0, 4'h0, "mixed");
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {led2, led}, 8'hF0);
        model_reset();
        step(1'b1, 8'hAE, 4'hF, 1'b0, 4'h0, "rst_event_ignored");
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 8'hAE, 4'h0, 1'b0, 4'h0, "post_rst");
        end

        // Random traffic against the model.
        for (int j = 0; j < 80; j++) begin
            step(1'b0, 8'($urandom), 4'($urandom) & 4'($urandom) & 4'($urandom),
                 1'b0, 4'h0, "random");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
